window_gen_5x5: RTL
===================

# window_gen_5x5

Streaming 5x5 window generator feeding the 5x5 image-filter stage of the post-decode pixel path. Accepts 8-bit grayscale pixels in raster order over a valid/ready handshake and buffers four image lines in internal line buffers. For every pixel position with a full 5x5 neighbourhood inside the frame, it emits one registered 200-bit window in the row-major packing the filter stage consumes. Border pixels produce no window, so each frame yields (IMG_WIDTH-4)*(IMG_HEIGHT-4) windows.

## Interface
- IMG_WIDTH, 64: pixels per line; legal range is at least 5.
- IMG_HEIGHT, 64: lines per frame; legal range is at least 5.
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- pixel_in  input  8  input pixel, unsigned.
- in_valid  input  1  pixel_in is valid.
- in_sof  input  1  qualifies pixel_in as frame pixel (0,0); meaningful only when in_valid is high.
- in_ready  output  1  block can accept a pixel this cycle.
- window_out  output  200  5x5 window; byte 5*r+c sits at bits [8*(5*r+c)+7 : 8*(5*r+c)], where r = row (0 = top) and c = column (0 = left). The centre pixel is at bits [103:96].
- out_valid  output  1  window_out is valid.
- out_ready  input  1  downstream accepts the window.
- out_last  output  1  qualifies the final window of the frame.

## Operation
- Accept: a pixel is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready (combinational). The output stage is a single register.
- Position counters: x in [0, IMG_WIDTH-1] and y in [0, IMG_HEIGHT-1] hold the position of the next pixel to accept.
  - On accept, x increments.
  - At x = IMG_WIDTH-1, x wraps to 0 and y increments.
  - At y = IMG_HEIGHT-1 with x = IMG_WIDTH-1, both wrap to 0. Frames run back to back.
- in_sof: an accepted pixel with in_sof=1 is treated as position (0,0), whatever the counter values. The counters then advance from (0,0), so the next position is (1,0). Any partial frame is abandoned, and no window from it is emitted after this accept.
- Line buffers: four buffers lb0..lb3, each IMG_WIDTH x 8 bits.
  - lb0 holds row y-1; lb3 holds row y-4.
  - On accept at column x: read lbk[x]. Write lb0[x] = pixel_in and lbk[x] = old lb(k-1)[x] for k = 1..3.
  - Line buffer contents are not reset.
- Window register: 5x5 bytes. On every accept, columns shift left: column c takes column c+1.
  - New column 4, top to bottom: lb3[x], lb2[x], lb1[x], lb0[x], pixel_in.
- Emit condition: an accept at (x,y) with x >= 4 and y >= 4, after in_sof handling.
  - window_out takes the updated window, which covers pixels (x-4..x, y-4..y) with centre (x-2, y-2).
  - out_valid is set.
  - out_last = (x == IMG_WIDTH-1 && y == IMG_HEIGHT-1).
- Output clearing: if out_valid && out_ready and there is no new emit in the same cycle, out_valid and out_last clear.
- Output holding: while out_valid && !out_ready, window_out, out_valid and out_last hold stable. No pixel is accepted while holding.
- Simultaneous out_ready and a new emit: the register reloads with no bubble.
- Arithmetic: all data is pass-through; no arithmetic on pixel values.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - x = 0, y = 0.
  - out_valid = 0, out_last = 0, window_out = 0.
  - in_ready = 1 after reset.
- Latency: the window appears on the edge that accepts its bottom-right pixel, so out_valid is high in the following cycle (1-cycle latency).
- Throughput: one pixel per cycle, and one window per cycle in the interior, when out_ready is held high.
- Reset mid-frame: all counters and output state return to reset values. The next accepted pixel is (0,0), and windows restart only after four new lines plus five pixels.

## Test plan
- Basic fill: IMG_WIDTH = IMG_HEIGHT = 8; stream pixel(x,y) = 8y+x with out_ready = 1 and in_sof on the first pixel.
  - First out_valid comes one cycle after the 37th accept.
  - window_out byte0 = 0, byte12 = 18, byte24 = 36.
  - Exactly 16 windows per frame.
  - out_last only on the window with byte24 = 63.
- Row boundary: in the same stream, no window is emitted for accepts at x < 4.
  - The window after (4,5) has byte0 = 8, byte12 = 26 and byte24 = 44, with no stale row-4 columns.
- Backpressure: hold out_ready = 0 for 5 cycles after the first window.
  - window_out, out_valid and out_last stay stable; in_ready = 0.
  - On release, the next window (byte12 = 19) follows with no loss or duplication.
- Back-to-back frames: two 8x8 frames streamed contiguously, with in_sof on each first pixel.
  - Frame 2 windows are identical to frame 1 windows.
  - 32 total windows and two out_last pulses.
- Resync: after 20 pixels of a frame, assert in_sof on the next pixel, then stream a full 8x8 frame.
  - Exactly 16 correct windows follow, with no window built from pre-resync data.
- Async reset: assert rst_n = 0 mid-frame between clock edges.
  - out_valid, out_last and window_out go to 0 immediately.
  - A subsequent full frame produces 16 correct windows.

Source files
------------

// File: rtl/window_gen_5x5.sv
// rtl/window_gen_5x5.sv - streaming 5x5 window generator over four line buffers
// Emits one registered 200-bit window per interior pixel, raster order.
module window_gen_5x5 #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   pixel_in,
  input  logic         in_valid,
  input  logic         in_sof,
  output logic         in_ready,
  output logic [199:0] window_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0] x_q, x_d, x_cur;
  logic [YW-1:0] y_q, y_d, y_cur;
  logic          accept, emit;

  logic [7:0] lb0_q [IMG_WIDTH];
  logic [7:0] lb1_q [IMG_WIDTH];
  logic [7:0] lb2_q [IMG_WIDTH];
  logic [7:0] lb3_q [IMG_WIDTH];
  logic [7:0] rd0, rd1, rd2, rd3;

  logic [24:0][7:0] win_q, win_d;
  logic [199:0]     window_q, window_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  assign in_ready   = !valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign window_out = window_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;

  // in_sof forces the accepted pixel to (0,0) regardless of the counters
  assign x_cur = in_sof ? '0 : x_q;
  assign y_cur = in_sof ? '0 : y_q;

  assign rd0 = lb0_q[x_cur];
  assign rd1 = lb1_q[x_cur];
  assign rd2 = lb2_q[x_cur];
  assign rd3 = lb3_q[x_cur];

  assign emit = accept && (x_cur >= XW'(4)) && (y_cur >= YW'(4));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (x_cur == X_LAST) begin
        x_d = '0;
        y_d = (y_cur == Y_LAST) ? '0 : y_cur + YW'(1);
      end else begin
        x_d = x_cur + XW'(1);
        y_d = y_cur;
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_d[5*r+c] = win_q[5*r+c+1];
        end
      end
      win_d[4]  = rd3;
      win_d[9]  = rd2;
      win_d[14] = rd1;
      win_d[19] = rd0;
      win_d[24] = pixel_in;
    end
  end

  // Single-entry output register: reload on emit, clear only on a drained slot
  always_comb begin
    window_d = window_q;
    valid_d  = valid_q;
    last_d   = last_q;
    if (emit) begin
      window_d = win_d;
      valid_d  = 1'b1;
      last_d   = (x_cur == X_LAST) && (y_cur == Y_LAST);
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      window_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      window_q <= window_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  // Line buffers and the shift window are data-only and left unreset
  always_ff @(posedge clk) begin
    win_q <= win_d;
    if (accept) begin
      lb0_q[x_cur] <= pixel_in;
      lb1_q[x_cur] <= rd0;
      lb2_q[x_cur] <= rd1;
      lb3_q[x_cur] <= rd2;
    end
  end

endmodule
